store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered stores (power of two, 2..8).
REQ-002 SHALL have parameter AW, default 8: data-memory address width.
REQ-003 SHALL have parameter DW, default 16: data width.
REQ-004 SHALL have port Clk, input, 1: the block's single clock; all state updates on the rising edge.
REQ-005 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port St_Valid, input, 1: store request from the register-file side.
REQ-007 SHALL have port St_Ready, output, 1: buffer can accept a store this cycle.
REQ-008 SHALL have port St_Addr, input, AW: store address.
REQ-009 SHALL have port St_Data, input, DW: store data (register-file read value).
REQ-010 SHALL have port Mem_Wr, output, 1: data-memory write strobe.
REQ-011 SHALL have port Mem_Addr, output, AW: data-memory write address.
REQ-012 SHALL have port Mem_Data, output, DW: data-memory write data.
REQ-013 SHALL have port Mem_Ack, input, 1: memory accepted the write this cycle.
REQ-014 SHALL have port Ld_Addr, input, AW: load address for forwarding lookup.
REQ-015 SHALL have port Ld_Hit, output, 1: a buffered store matches Ld_Addr.
REQ-016 SHALL have port Ld_Data, output, DW: forwarded store data.
REQ-017 SHALL have port Count, output, 4: current occupancy, 0..DEPTH.
REQ-018 SHALL have port Empty, output, 1: Count == 0.

Function
REQ-019 SHALL hold stores in a circular FIFO of DEPTH entries {addr, data}, with head/tail pointers wrapping modulo DEPTH.
REQ-020 SHALL drive St_Ready = (Count < DEPTH); a push occurs at an edge where St_Valid && St_Ready.
REQ-021 SHALL ignore St_Valid when St_Ready is 0; the store is not captured and there is no error flag.
REQ-022 SHALL implement a two-state FSM, IDLE and WRITE; Mem_Wr = (state == WRITE).
REQ-023 SHALL move IDLE->WRITE at an edge where Count > 0, using Count before that edge; IDLE stays IDLE when Count == 0.
REQ-024 SHALL drive Mem_Addr/Mem_Data from the head entry, held stable while Mem_Wr is high until Mem_Ack; both are 0 when Empty.
REQ-025 SHALL pop the head at an edge where state == WRITE && Mem_Ack, then:
- stay in WRITE if Count after the pop is > 0 (back-to-back writes, no bubble);
- otherwise go to IDLE.
REQ-026 SHALL ignore Mem_Ack while Mem_Wr is 0.
REQ-027 SHALL set minimum latency from push edge k to Mem_Wr high at edge k+1, i.e. Mem_Wr is visible in the cycle after the push is registered.
REQ-028 SHALL, on simultaneous push and pop at one edge, leave Count unchanged and perform both updates; this is allowed only when St_Ready was 1, so there is no pass-through when full.
REQ-029 SHALL compute Ld_Hit combinationally: 1 if any occupied entry, including a head currently being written, has addr == Ld_Addr.
REQ-030 SHALL drive Ld_Data with the data of the newest (closest to tail) matching entry, or 0 when Ld_Hit is 0.
REQ-031 SHALL preserve store order to memory exactly as pushed; entries to the same address are not merged.

Reset
REQ-032 SHALL, when Reset is high at an edge, set state IDLE, Count 0, head/tail 0 and discard all entries.
REQ-033 SHALL have after reset: Mem_Wr 0, Mem_Addr 0, Mem_Data 0, St_Ready 1, Empty 1, Ld_Hit 0, Ld_Data 0.
REQ-034 SHALL, on reset mid-WRITE, drop Mem_Wr in the cycle after the reset edge regardless of Mem_Ack; the pending write is abandoned.
REQ-035 SHALL give Reset priority over a simultaneous push, pop or Mem_Ack.

Verification
REQ-036 SHALL cover single store: push addr 0x10 data 0xBEEF, Mem_Ack tied 1 -> Mem_Wr high one cycle after push with 0x10/0xBEEF, Count returns 0, Empty 1.
REQ-037 SHALL cover fill and stall: Mem_Ack 0, push 0x01..0x04 -> Count 4, St_Ready 0; a 5th St_Valid is dropped; Mem_Addr stays 0x01 while Mem_Wr is high.
REQ-038 SHALL cover drain order: from full, Mem_Ack 1 -> writes 0x01,0x02,0x03,0x04 on four consecutive cycles, then IDLE, Mem_Wr 0.
REQ-039 SHALL cover forwarding: push (0x20,0x1111) then (0x20,0x2222), Mem_Ack 0, Ld_Addr 0x20 -> Ld_Hit 1, Ld_Data 0x2222; Ld_Addr 0x21 -> Ld_Hit 0, Ld_Data 0.
REQ-040 SHALL cover simultaneous push/pop: Count 2, St_Valid 1 and Mem_Ack 1 in the same cycle -> Count stays 2, tail wraps correctly past DEPTH-1.
REQ-041 SHALL cover reset mid-write: Mem_Wr high, Mem_Ack 0, assert Reset -> next cycle Mem_Wr 0, Count 0, St_Ready 1.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer
//   Circular FIFO of DEPTH {addr, data} stores sitting between the register
//   file and a single-port data memory. Stores drain to memory in program
//   order through a two-state write FSM. Loads can pick up data that has not
//   reached memory yet: the buffer is searched and the newest matching store
//   is forwarded.
//
// Ports
//   Clk, Reset           clock and synchronous active-high reset
//   St_Valid/St_Ready    store handshake; St_Addr/St_Data are the store
//   Mem_Wr/Mem_Ack       memory write strobe and write acknowledge
//   Mem_Addr/Mem_Data    head entry being written (0 when empty)
//   Ld_Addr              load address for forwarding lookup
//   Ld_Hit/Ld_Data       forwarding result (combinational)
//   Count/Empty          occupancy
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          St_Valid,
    output logic          St_Ready,
    input  logic [AW-1:0] St_Addr,
    input  logic [DW-1:0] St_Data,
    output logic          Mem_Wr,
    output logic [AW-1:0] Mem_Addr,
    output logic [DW-1:0] Mem_Data,
    input  logic          Mem_Ack,
    input  logic [AW-1:0] Ld_Addr,
    output logic          Ld_Hit,
    output logic [DW-1:0] Ld_Data,
    output logic [3:0]    Count,
    output logic          Empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [3:0]      count_q, count_d;
    logic            push, pop;

    // Payload storage carries no reset; occupancy alone decides validity.
    logic [AW-1:0]   ent_addr_q [DEPTH];
    logic [DW-1:0]   ent_data_q [DEPTH];

    assign St_Ready = (count_q < 4'(DEPTH));
    assign Mem_Wr   = (state_q == WRITE);
    assign Count    = count_q;
    assign Empty    = (count_q == 4'd0);

    always_comb begin
        push    = St_Valid && St_Ready;
        // WRITE is only ever held while the buffer is non-empty, so an ack
        // in WRITE always has a head entry to retire.
        pop     = (state_q == WRITE) && Mem_Ack;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE:    if (count_q != 4'd0) state_d = WRITE;
            // Stay in WRITE after a pop while anything remains (including a
            // store pushed on the same edge) so writes run back to back.
            WRITE:   if (pop && (count_d == 4'd0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Mem_Addr = '0;
        Mem_Data = '0;
        if (!Empty) begin
            Mem_Addr = ent_addr_q[head_q];
            Mem_Data = ent_data_q[head_q];
        end
    end

    // Walk from oldest to newest so the last match wins, giving the store
    // closest to the tail. Slots beyond the occupancy are never considered.
    always_comb begin
        Ld_Hit  = 1'b0;
        Ld_Data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((4'(i) < count_q) && (ent_addr_q[head_q + PW'(i)] == Ld_Addr)) begin
                Ld_Hit  = 1'b1;
                Ld_Data = ent_data_q[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            ent_addr_q[tail_q] <= St_Addr;
            ent_data_q[tail_q] <= St_Data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed bench for store_buffer (default parameters: DEPTH 4, AW 8,
//   DW 16). A table of per-cycle rows gives the inputs driven in a cycle and
//   the outputs expected in that same cycle, before the next rising edge.
//   Reset-during-write cases are written out as explicit sequences.
module tb_store_buffer;

    logic        Clk;
    logic        Reset;
    logic        St_Valid;
    logic        St_Ready;
    logic [7:0]  St_Addr;
    logic [15:0] St_Data;
    logic        Mem_Wr;
    logic [7:0]  Mem_Addr;
    logic [15:0] Mem_Data;
    logic        Mem_Ack;
    logic [7:0]  Ld_Addr;
    logic        Ld_Hit;
    logic [15:0] Ld_Data;
    logic [3:0]  Count;
    logic        Empty;

    store_buffer #(.DEPTH(4), .AW(8), .DW(16)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .St_Valid (St_Valid),
        .St_Ready (St_Ready),
        .St_Addr  (St_Addr),
        .St_Data  (St_Data),
        .Mem_Wr   (Mem_Wr),
        .Mem_Addr (Mem_Addr),
        .Mem_Data (Mem_Data),
        .Mem_Ack  (Mem_Ack),
        .Ld_Addr  (Ld_Addr),
        .Ld_Hit   (Ld_Hit),
        .Ld_Data  (Ld_Data),
        .Count    (Count),
        .Empty    (Empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        sv;
        logic [7:0]  sa;
        logic [15:0] sd;
        logic        ack;
        logic [7:0]  la;
        logic        rdy;
        logic        wr;
        logic [7:0]  ma;
        logic [15:0] md;
        logic        hit;
        logic [15:0] ld;
        logic [3:0]  cnt;
        logic        emp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic sv, input logic [7:0] sa, input logic [15:0] sd,
                       input logic ack, input logic [7:0] la,
                       input logic rdy, input logic wr, input logic [7:0] ma,
                       input logic [15:0] md, input logic hit, input logic [15:0] ld,
                       input logic [3:0] cnt, input logic emp);
        vec_t v;
        v = '{sv, sa, sd, ack, la, rdy, wr, ma, md, hit, ld, cnt, emp};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic rdy, input logic wr,
                           input logic [7:0] ma, input logic [15:0] md,
                           input logic hit, input logic [15:0] ld,
                           input logic [3:0] cnt, input logic emp);
        chk("St_Ready", row, 16'(St_Ready), 16'(rdy));
        chk("Mem_Wr",   row, 16'(Mem_Wr),   16'(wr));
        chk("Mem_Addr", row, 16'(Mem_Addr), 16'(ma));
        chk("Mem_Data", row, Mem_Data,      md);
        chk("Ld_Hit",   row, 16'(Ld_Hit),   16'(hit));
        chk("Ld_Data",  row, Ld_Data,       ld);
        chk("Count",    row, 16'(Count),    16'(cnt));
        chk("Empty",    row, 16'(Empty),    16'(emp));
    endtask

    task automatic drive(input logic rst, input logic sv, input logic [7:0] sa,
                         input logic [15:0] sd, input logic ack, input logic [7:0] la);
        @(negedge Clk);
        Reset    = rst;
        St_Valid = sv;
        St_Addr  = sa;
        St_Data  = sd;
        Mem_Ack  = ack;
        Ld_Addr  = la;
        #1;
    endtask

    initial begin
        Reset    = 1'b1;
        St_Valid = 1'b0;
        St_Addr  = '0;
        St_Data  = '0;
        Mem_Ack  = 1'b0;
        Ld_Addr  = '0;

        //   sv  addr   data      ack la     | rdy wr ma     md        hit ld        cnt emp
        // post-reset idle
        add(0, 8'h00, 16'h0000, 0, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);
        // single store with ack held high
        add(1, 8'h10, 16'hBEEF, 1, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);
        add(0, 8'h00, 16'h0000, 1, 8'h10,   1, 0, 8'h10, 16'hBEEF, 1, 16'hBEEF, 4'd1, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h10,   1, 1, 8'h10, 16'hBEEF, 1, 16'hBEEF, 4'd1, 0);
        add(0, 8'h00, 16'h0000, 0, 8'h10,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);
        // fill to full with ack low, fifth store dropped
        add(1, 8'h01, 16'h0A01, 0, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);
        add(1, 8'h02, 16'h0A02, 0, 8'h00,   1, 0, 8'h01, 16'h0A01, 0, 16'h0000, 4'd1, 0);
        add(1, 8'h03, 16'h0A03, 0, 8'h00,   1, 1, 8'h01, 16'h0A01, 0, 16'h0000, 4'd2, 0);
        add(1, 8'h04, 16'h0A04, 0, 8'h00,   1, 1, 8'h01, 16'h0A01, 0, 16'h0000, 4'd3, 0);
        add(1, 8'h05, 16'h0A05, 0, 8'h05,   0, 1, 8'h01, 16'h0A01, 0, 16'h0000, 4'd4, 0);
        add(0, 8'h00, 16'h0000, 0, 8'h05,   0, 1, 8'h01, 16'h0A01, 0, 16'h0000, 4'd4, 0);
        // drain in order on consecutive cycles
        add(0, 8'h00, 16'h0000, 1, 8'h04,   0, 1, 8'h01, 16'h0A01, 1, 16'h0A04, 4'd4, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h01,   1, 1, 8'h02, 16'h0A02, 0, 16'h0000, 4'd3, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h04,   1, 1, 8'h03, 16'h0A03, 1, 16'h0A04, 4'd2, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h04,   1, 1, 8'h04, 16'h0A04, 1, 16'h0A04, 4'd1, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h04,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);
        // forwarding picks the newest of two same-address stores
        add(1, 8'h20, 16'h1111, 0, 8'h20,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);
        add(1, 8'h20, 16'h2222, 0, 8'h20,   1, 0, 8'h20, 16'h1111, 1, 16'h1111, 4'd1, 0);
        add(0, 8'h00, 16'h0000, 0, 8'h20,   1, 1, 8'h20, 16'h1111, 1, 16'h2222, 4'd2, 0);
        add(0, 8'h00, 16'h0000, 0, 8'h21,   1, 1, 8'h20, 16'h1111, 0, 16'h0000, 4'd2, 0);
        // simultaneous push and pop, tail wraps 3 -> 0
        add(1, 8'h30, 16'h3030, 1, 8'h30,   1, 1, 8'h20, 16'h1111, 0, 16'h0000, 4'd2, 0);
        add(1, 8'h31, 16'h3131, 1, 8'h30,   1, 1, 8'h20, 16'h2222, 1, 16'h3030, 4'd2, 0);
        add(1, 8'h32, 16'h3232, 1, 8'h31,   1, 1, 8'h30, 16'h3030, 1, 16'h3131, 4'd2, 0);
        add(0, 8'h00, 16'h0000, 0, 8'h32,   1, 1, 8'h31, 16'h3131, 1, 16'h3232, 4'd2, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h20,   1, 1, 8'h31, 16'h3131, 0, 16'h0000, 4'd2, 0);
        add(0, 8'h00, 16'h0000, 1, 8'h32,   1, 1, 8'h32, 16'h3232, 1, 16'h3232, 4'd1, 0);
        add(0, 8'h00, 16'h0000, 0, 8'h32,   1, 0, 8'h00, 16'h0000, 0, 16'h0000, 4'd0, 1);

        repeat (2) @(posedge Clk);

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].ack, vecs[i].la);
            chk_all(i, vecs[i].rdy, vecs[i].wr, vecs[i].ma, vecs[i].md,
                    vecs[i].hit, vecs[i].ld, vecs[i].cnt, vecs[i].emp);
        end

        // Reset mid-write with ack low and a competing push.
        drive(1'b0, 1'b1, 8'h40, 16'h4040, 1'b0, 8'h40);
        drive(1'b0, 1'b1, 8'h41, 16'h4141, 1'b0, 8'h40);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h40);
        chk("pre-reset Mem_Wr", 100, 16'(Mem_Wr), 16'h1);
        chk("pre-reset Count",  100, 16'(Count),  16'h2);
        drive(1'b1, 1'b1, 8'h42, 16'h4242, 1'b0, 8'h40);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h40);
        chk_all(101, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h42);
        chk_all(102, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1);

        // Reset beats a same-edge ack on the last entry.
        drive(1'b0, 1'b1, 8'h50, 16'h5050, 1'b0, 8'h50);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h50);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h50);
        chk("pre-reset2 Mem_Wr", 103, 16'(Mem_Wr), 16'h1);
        drive(1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h50);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h50);
        chk_all(104, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
